// File: rtl/lcd_sequencer.sv
// Purpose: HD44780-style character LCD sequencer; power-up wait, init sequence, 2x16 refresh from a frame buffer.
// Latency: a refresh starts the cycle after i_start in IDLE; each transfer is SETUP+STROBE+HOLD plus a T_SHORT/T_LONG wait.
// Backpressure: none; i_start is only sampled in IDLE and is dropped (never queued) while busy.
//
// Ports:
//   i_clk       sole clock, rising edge
//   i_rst       synchronous active-high reset; restarts the power-up wait and init sequence
//   i_start     refresh request, sampled in IDLE only
//   i_char      frame-buffer read data, valid one cycle after o_buf_addr (synchronous RAM)
//   o_buf_addr  frame-buffer address, 0..15 line 1, 16..31 line 2
//   o_data      LCD bus byte (registered)
//   o_rs        0 = command, 1 = data (registered)
//   o_rw        tied low, write-only bus
//   o_E         enable strobe, registered, high only in STROBE
//   o_busy      low only in IDLE
//   o_done      one-cycle pulse when a refresh finishes
module lcd_sequencer #(
    parameter int T_PWRUP = 40000,
    parameter int T_LONG  = 4000,
    parameter int T_SHORT = 113
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_char,
    output logic [4:0] o_buf_addr,
    output logic [7:0] o_data,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_E,
    output logic       o_busy,
    output logic       o_done
);

    // One shared wait counter serves both the power-up delay and the
    // post-transfer waits, so it is sized for the longer of the two.
    localparam int WAIT_MAX = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
    localparam int CW       = $clog2(WAIT_MAX + 1);

    localparam logic [CW-1:0] PWRUP_LAST = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(T_LONG - 1);
    localparam logic [CW-1:0] SHORT_LAST = CW'(T_SHORT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [7:0] CMD_LINE1 = 8'h80;   // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2 = 8'hC0;   // DDRAM address 0x40

    typedef enum logic [3:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [4:0]      char_idx;
    logic [1:0]      init_idx;
    logic            in_init;       // transfers belong to the init sequence
    logic            cmd_pending;   // next ADDR issues a line-address command
    logic            long_xfer;
    logic [CW-1:0]   wait_last;

    // Init sequence: 8-bit bus / 2 lines, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h01;
            default: cmd = 8'h06;
        endcase
        return cmd;
    endfunction

    // The bus still holds the byte just transferred during WAIT, so the
    // wait length is decided from it: clear and return-home are slow.
    assign long_xfer = !o_rs && ((o_data == 8'h01) || (o_data == 8'h02));
    assign wait_last = long_xfer ? LONG_LAST : SHORT_LAST;

    assign o_rw = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_PWRUP;
            wait_cnt    <= '0;
            char_idx    <= '0;
            init_idx    <= '0;
            in_init     <= 1'b1;
            cmd_pending <= 1'b0;
            o_buf_addr  <= '0;
            o_data      <= '0;
            o_rs        <= 1'b0;
            o_E         <= 1'b0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
        end else begin
            // Strobe and done are single-cycle; only their entry edges set them.
            o_E    <= 1'b0;
            o_done <= 1'b0;

            case (state)
                S_PWRUP: begin
                    if (wait_cnt == PWRUP_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_INIT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end

                S_INIT: begin
                    o_data <= init_cmd(init_idx);
                    o_rs   <= 1'b0;
                    state  <= S_SETUP;
                end

                S_IDLE: begin
                    if (i_start) begin
                        o_busy      <= 1'b1;
                        cmd_pending <= 1'b1;
                        char_idx    <= '0;
                        o_buf_addr  <= '0;
                        state       <= S_ADDR;
                    end
                end

                // o_buf_addr is already presented here, so the RAM read
                // launched at the ADDR->LOAD edge lands on i_char in LOAD.
                S_ADDR: begin
                    if (cmd_pending) begin
                        // Line-address command sits before index 0 and index 16.
                        o_data <= char_idx[4] ? CMD_LINE2 : CMD_LINE1;
                        o_rs   <= 1'b0;
                        state  <= S_SETUP;
                    end else begin
                        state  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    o_data <= i_char;
                    o_rs   <= 1'b1;
                    state  <= S_SETUP;
                end

                S_SETUP: begin
                    o_E   <= 1'b1;
                    state <= S_STROBE;
                end

                S_STROBE: begin
                    state <= S_HOLD;
                end

                S_HOLD: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == wait_last) begin
                        wait_cnt <= '0;
                        if (in_init) begin
                            if (init_idx == 2'd3) begin
                                // Init ends silently in IDLE; no refresh, no done pulse.
                                in_init  <= 1'b0;
                                init_idx <= '0;
                                o_busy   <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                state    <= S_INIT;
                            end
                        end else if (!o_rs) begin
                            // Line-address command sent; continue with the characters.
                            cmd_pending <= 1'b0;
                            state       <= S_ADDR;
                        end else if (char_idx == 5'd31) begin
                            // Index wraps so a new refresh never inherits it.
                            char_idx   <= '0;
                            o_buf_addr <= '0;
                            o_done     <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            char_idx    <= char_idx + 5'd1;
                            o_buf_addr  <= char_idx + 5'd1;
                            cmd_pending <= (char_idx == 5'd15);
                            state       <= S_ADDR;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end

                // i_start is not looked at here; a request held across DONE
                // is only seen once IDLE is reached.
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    wait_cnt <= '0;
                    o_busy   <= 1'b1;
                    state    <= S_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
module tb_lcd_sequencer;

    localparam int TP = 20;
    localparam int TL = 10;
    localparam int TS = 3;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_char;
    logic [4:0] o_buf_addr;
    logic [7:0] o_data;
    logic       o_rs;
    logic       o_rw;
    logic       o_E;
    logic       o_busy;
    logic       o_done;

    always #5 clk = ~clk;

    lcd_sequencer #(
        .T_PWRUP (TP),
        .T_LONG  (TL),
        .T_SHORT (TS)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_char     (i_char),
        .o_buf_addr (o_buf_addr),
        .o_data     (o_data),
        .o_rs       (o_rs),
        .o_rw       (o_rw),
        .o_E        (o_E),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Frame buffer with one-cycle synchronous read.
    logic [7:0] fbuf [32];
    always @(posedge clk) i_char <= fbuf[o_buf_addr];

    int nvec = 0;
    int nerr = 0;

    // Scoreboard: expected LCD transfers as {rs, byte}, and expected done pulses.
    logic [8:0] sb_q [$];
    int exp_done  = 0;
    int done_seen = 0;
    int pulse_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_init();
        sb_q.push_back({1'b0, 8'h38});
        sb_q.push_back({1'b0, 8'h0C});
        sb_q.push_back({1'b0, 8'h01});
        sb_q.push_back({1'b0, 8'h06});
    endtask

    // Reference refresh: line-1 address, chars 0..15, line-2 address, chars 16..31, done.
    task automatic push_refresh();
        sb_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) sb_q.push_back({1'b1, fbuf[i]});
        sb_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) sb_q.push_back({1'b1, fbuf[i]});
        exp_done++;
    endtask

    // ---------------- monitor ----------------
    logic       prev_E = 1'b0, prev_rs = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         low_cnt = 0;
    logic       have_prev = 1'b0, prev_long = 1'b0, after_rst = 1'b0, chk_hold = 1'b0;
    logic [8:0] held, exp_x;

    always @(negedge clk) begin
        if (i_rst) begin
            low_cnt   = 0;
            have_prev = 1'b0;
            after_rst = 1'b1;
            chk_hold  = 1'b0;
        end else begin
            if (chk_hold) begin
                chk("hold_bus", {23'd0, o_rs, o_data}, {23'd0, held});
                chk_hold = 1'b0;
            end
            if (o_E) begin
                pulse_cnt++;
                chk("e_single", {31'd0, prev_E}, 32'd0);
                chk("setup_bus", {23'd0, prev_rs, prev_data}, {23'd0, o_rs, o_data});
                chk("rw_low", {31'd0, o_rw}, 32'd0);
                chk("busy_in_xfer", {31'd0, o_busy}, 32'd1);
                if (sb_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_xfer: got rs=%0d data=%02h expected no transfer (t=%0t)",
                             o_rs, o_data, $time);
                end else begin
                    exp_x = sb_q.pop_front();
                    chk("xfer", {23'd0, o_rs, o_data}, {23'd0, exp_x});
                end
                // Low cycles between strobes: at least HOLD + WAIT + SETUP.
                if (have_prev) begin
                    if (prev_long)
                        chk("gap_long", {31'd0, low_cnt >= TL + 2}, 32'd1);
                    else
                        chk("gap_short", {31'd0, (low_cnt >= TS + 2) && (low_cnt < TL + 2)}, 32'd1);
                end else if (after_rst) begin
                    chk("pwrup_gap", {31'd0, low_cnt >= TP}, 32'd1);
                end
                after_rst = 1'b0;
                have_prev = 1'b1;
                prev_long = !o_rs && ((o_data == 8'h01) || (o_data == 8'h02));
                held      = {o_rs, o_data};
                chk_hold  = 1'b1;
                low_cnt   = 0;
            end else begin
                low_cnt++;
            end
            if (o_done) begin
                chk("done_single", {31'd0, prev_done}, 32'd0);
                if (exp_done == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done: got o_done=1 expected 0 (t=%0t)", $time);
                end else begin
                    exp_done--;
                    chk("done_drain", sb_q.size(), 32'd0);
                end
                done_seen++;
                have_prev = 1'b0;
            end
            if (!o_busy) have_prev = 1'b0;
        end
        prev_E    = o_E;
        prev_rs   = o_rs;
        prev_data = o_data;
        prev_done = o_done;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_seen;
        int n  = 0;
        while (done_seen == d0 && n < budget) begin
            step();
            n++;
        end
        chk(name, done_seen - d0, 32'd1);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) fbuf[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 32; i++) fbuf[i] = 8'(8'h41 + i);
    endtask

    task automatic check_reset_vals(input string name);
        chk(name, {13'd0, o_E, o_rs, o_rw, o_data, o_buf_addr, o_busy, o_done},
            {13'd0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0});
    endtask

    initial begin
        int p0;
        int n;
        i_rst   = 1'b1;
        i_start = 1'b0;
        fill_ramp();
        repeat (3) step();
        check_reset_vals("reset_vals");

        // Power-up and init; must end idle with no done pulse.
        push_init();
        i_rst = 1'b0;
        wait_idle("init_idle", 1000);
        chk("init_drain", sb_q.size(), 32'd0);
        chk("init_no_done", done_seen, 32'd0);

        // Ramp pattern refresh.
        push_refresh();
        pulse_start();
        wait_done("ramp_done", 3000);
        step();
        chk("ramp_idle", {31'd0, o_busy}, 32'd0);

        // Random contents, random idle delays, stray start pulses while busy.
        repeat (3) begin
            fill_random();
            repeat ($urandom_range(0, 10)) step();
            push_refresh();
            pulse_start();
            repeat ($urandom_range(10, 150)) step();
            i_start = 1'b1;
            step();
            i_start = 1'b0;
            wait_done("rand_done", 3000);
            repeat (40) step();
            chk("rand_no_extra", {31'd0, o_busy}, 32'd0);
        end

        // i_start held through a whole refresh, dropped while DONE is showing.
        fill_random();
        push_refresh();
        i_start = 1'b1;
        wait_done("held_done", 3000);
        i_start = 1'b0;
        repeat (60) step();
        chk("held_single", {31'd0, o_busy}, 32'd0);
        chk("held_drain", sb_q.size(), 32'd0);
        push_refresh();
        pulse_start();
        wait_done("second_done", 3000);

        // Reset while the strobe of data index 7 is high.
        repeat (5) step();
        fill_ramp();
        push_refresh();
        p0 = pulse_cnt;
        pulse_start();
        n = 0;
        while (pulse_cnt != p0 + 9 && n < 3000) begin
            step();
            n++;
        end
        chk("reach_idx7", pulse_cnt - p0, 32'd9);
        i_rst = 1'b1;
        sb_q.delete();
        exp_done = 0;
        step();
        chk("rst_e_low", {31'd0, o_E}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd1);
        step();
        check_reset_vals("reset_vals_mid");
        push_init();
        i_rst = 1'b0;
        wait_idle("reinit_idle", 1000);
        chk("reinit_drain", sb_q.size(), 32'd0);

        // Refresh after the reset starts again from index 0.
        fill_random();
        push_refresh();
        pulse_start();
        wait_done("post_rst_done", 3000);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter T_PWRUP, default 40000: power-up wait in i_clk cycles before the first init command.
REQ-002 Parameter T_LONG, default 4000: post-transfer wait in cycles after clear (0x01) or return-home (0x02).
REQ-003 Parameter T_SHORT, default 113: post-transfer wait in cycles after any other command or data write.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  synchronous, active-high reset.
REQ-007 i_start  input  1  refresh request; sampled only in IDLE.
REQ-008 i_char  input  8  character from the frame buffer; valid one cycle after o_buf_addr (synchronous read).
REQ-009 o_buf_addr  output  5  frame-buffer address 0..31; 0..15 is line 1, 16..31 is line 2.
REQ-010 o_data  output  8  LCD bus byte, registered.
REQ-011 o_rs  output  1  0 = command, 1 = data, registered.
REQ-012 o_rw  output  1  tied 0; write only.
REQ-013 o_E  output  1  LCD enable strobe, registered, glitch-free.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_done  output  1  single-cycle pulse when a refresh completes.

Function
REQ-016 States: PWRUP, INIT, IDLE, ADDR, LOAD, SETUP, STROBE, HOLD, WAIT, DONE.
REQ-017 PWRUP: count T_PWRUP cycles, then go to INIT.
REQ-018 INIT issues commands 0x38, 0x0C, 0x01, 0x06 in order, each as one transfer (REQ-020), then goes to IDLE.
REQ-019 After the INIT sequence completes, IDLE is entered without any refresh and o_done is not asserted.
REQ-020 Transfer: SETUP (1 cycle, o_data/o_rs stable, o_E=0) -> STROBE (1 cycle, o_E=1) -> HOLD (1 cycle, o_E=0, bus unchanged) -> WAIT.
REQ-021 WAIT lasts T_LONG cycles if the transfer was a command of 0x01 or 0x02; otherwise it lasts T_SHORT cycles.
REQ-022 o_data and o_rs do not change from the SETUP cycle through the last WAIT cycle of a transfer.
REQ-023 In IDLE, i_start=1 starts a refresh on the next cycle; i_start is ignored in all other states, and no request is queued.
REQ-024 Refresh sequence: command 0x80; data for addresses 0..15; command 0xC0; data for addresses 16..31; DONE.
REQ-025 Data write: LOAD drives o_buf_addr for 1 cycle; i_char is captured into o_data at the LOAD->SETUP edge with o_rs=1.
REQ-026 The character index is a 5-bit counter.
REQ-027 After the data transfer for index 15, the sequencer inserts the 0xC0 command.
REQ-028 After the data transfer for index 31, the sequencer goes to DONE; the index wraps to 0 and is not carried into a new refresh.
REQ-029 DONE lasts 1 cycle with o_done=1, then the sequencer goes to IDLE.
REQ-030 i_start=1 in the same cycle as DONE is ignored.
REQ-031 A wait counter of width clog2(max(T_PWRUP, T_LONG)+1) is cleared on entry to every waiting state.
REQ-032 o_E is high for exactly 1 cycle per transfer and is never high outside STROBE.

Reset
REQ-033 i_rst=1 at any clock edge, including mid-transfer with o_E=1, puts the block in PWRUP with all counters 0.
REQ-034 Reset values: o_E=0, o_rs=0, o_rw=0, o_data=0x00, o_buf_addr=0, o_busy=1, o_done=0.
REQ-035 Leaving reset always replays the full power-up wait and INIT sequence.

Verification (T_PWRUP=20, T_LONG=10, T_SHORT=3)
REQ-036 Release reset -> 20 cycles idle bus; o_E pulses carry 0x38, 0x0C, 0x01, 0x06 with o_rs=0; the gap after 0x01 is 10 wait cycles and the others are 3; then o_busy=0 and o_done stays 0.
REQ-037 In IDLE, pulse i_start with buffer[i]=0x41+i -> 34 o_E pulses in order: 0x80, 0x41..0x50, 0xC0, 0x51..0x60; o_rs=1 only for data; one o_done pulse follows.
REQ-038 i_start held high through a refresh -> exactly one refresh; a second refresh starts only from IDLE after o_done.
REQ-039 Assert i_rst during STROBE of data index 7 -> the next cycle has o_E=0 and o_busy=1, and the full PWRUP+INIT sequence replays.
REQ-040 Throughout all scenarios -> o_E is never high for 2 consecutive cycles, and o_data/o_rs never change between SETUP and the end of HOLD.
